// File: rtl/instr_fetch_unit.sv
// Fetch stage: walks the PC through the asynchronous program memory, hands
// instructions to decode over valid/ready, and stops on the halt encoding.
module instr_fetch_unit #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hF800_0000,
    parameter int                CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic [DATA_W-1:0] INSTR,
    output logic [ADDR_W-1:0] INSTR_PC,
    output logic              INSTR_VALID,
    input  logic              INSTR_READY,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_PC,
    output logic              HALTED,
    output logic [CNT_W-1:0]  FETCH_COUNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              accept;
    logic              load;
    logic              is_halt;

    assign MEM_ADDR = pc;
    assign accept   = INSTR_VALID && INSTR_READY;
    assign load     = (state == RUN) && (!INSTR_VALID || accept) && !REDIRECT;
    assign is_halt  = (MEM_DATA == HALT_WORD);

    // NOTE: all state is updated with <= so every branch sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            INSTR       <= '0;
            INSTR_PC    <= '0;
            INSTR_VALID <= 1'b0;
            HALTED      <= 1'b0;
            FETCH_COUNT <= '0;
        end else begin
            // Accepted instructions count in every state, squashing cycles included.
            if (accept && (FETCH_COUNT != {CNT_W{1'b1}}))
                FETCH_COUNT <= FETCH_COUNT + 1'b1;

            case (state)
                IDLE: begin
                    if (START)
                        state <= RUN;
                end
                RUN: begin
                    if (REDIRECT) begin
                        pc          <= REDIRECT_PC;
                        INSTR_VALID <= 1'b0;
                    end else if (load) begin
                        INSTR       <= MEM_DATA;
                        INSTR_PC    <= pc;
                        INSTR_VALID <= 1'b1;
                        if (is_halt)
                            state <= DRAIN;
                        else
                            pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                DRAIN: begin
                    // A redirect here means the halt was on a mispredicted path.
                    if (REDIRECT) begin
                        pc          <= REDIRECT_PC;
                        INSTR_VALID <= 1'b0;
                        state       <= RUN;
                    end else if (accept) begin
                        INSTR_VALID <= 1'b0;
                        HALTED      <= 1'b1;
                        state       <= HALT;
                    end
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, stall, redirect,
// PC wrap, halt cancel and mid-run reset against a behavioural memory.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic [7:0]  MEM_ADDR;
    logic [31:0] MEM_DATA;
    logic [31:0] INSTR;
    logic [7:0]  INSTR_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic        REDIRECT;
    logic [7:0]  REDIRECT_PC;
    logic        HALTED;
    logic [15:0] FETCH_COUNT;

    logic [31:0] mem [256];
    logic [31:0] prog [10];
    int          errors = 0;
    int          checks = 0;

    assign MEM_DATA = mem[MEM_ADDR];

    always #5 CLK = ~CLK;

    instr_fetch_unit dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .START       (START),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_DATA    (MEM_DATA),
        .INSTR       (INSTR),
        .INSTR_PC    (INSTR_PC),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .HALTED      (HALTED),
        .FETCH_COUNT (FETCH_COUNT)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        prog = '{32'h0000_1111, 32'h2001_0001, 32'h1002_2000, 32'h3003_0003,
                 32'h4004_0004, 32'hD002_0000, 32'h6006_0006, 32'hF800_0001,
                 32'h8008_0008, 32'hF800_0000};
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 10; i++) mem[i] = prog[i];

        RESET_N = 1'b0; START = 1'b0; INSTR_READY = 1'b1;
        REDIRECT = 1'b0; REDIRECT_PC = 8'h00;

        // Reset state
        tick(); tick();
        check("rst_valid", {31'b0, INSTR_VALID}, 32'd0);
        check("rst_instr", INSTR, 32'd0);
        check("rst_instr_pc", {24'b0, INSTR_PC}, 32'd0);
        check("rst_halted", {31'b0, HALTED}, 32'd0);
        check("rst_count", {16'b0, FETCH_COUNT}, 32'd0);
        check("rst_mem_addr", {24'b0, MEM_ADDR}, 32'd0);

        // Straight-line run to the halt word
        RESET_N = 1'b1;
        tick();
        check("idle_no_fetch", {31'b0, INSTR_VALID}, 32'd0);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_cycle_valid", {31'b0, INSTR_VALID}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("run_pc_%0d", i), {24'b0, INSTR_PC}, i);
            check($sformatf("run_instr_%0d", i), INSTR, prog[i]);
            check($sformatf("run_valid_%0d", i), {31'b0, INSTR_VALID}, 32'd1);
            check($sformatf("run_count_%0d", i), {16'b0, FETCH_COUNT}, i);
        end
        tick();
        check("halt_halted", {31'b0, HALTED}, 32'd1);
        check("halt_count", {16'b0, FETCH_COUNT}, 32'd10);
        check("halt_valid", {31'b0, INSTR_VALID}, 32'd0);
        check("halt_mem_addr", {24'b0, MEM_ADDR}, 32'd9);

        // HALT ignores START and REDIRECT
        START = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 8'h40;
        tick();
        START = 1'b0; REDIRECT = 1'b0;
        tick();
        check("halt_sticky", {31'b0, HALTED}, 32'd1);
        check("halt_pc_frozen", {24'b0, MEM_ADDR}, 32'd9);
        check("halt_no_fetch", {31'b0, INSTR_VALID}, 32'd0);

        // Stall with READY low while instruction 2 is presented
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick(); tick();
        check("stall_pc2", {24'b0, INSTR_PC}, 32'd2);
        INSTR_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_instr_%0d", i), INSTR, 32'h1002_2000);
            check($sformatf("stall_instr_pc_%0d", i), {24'b0, INSTR_PC}, 32'd2);
            check($sformatf("stall_mem_addr_%0d", i), {24'b0, MEM_ADDR}, 32'd3);
            check($sformatf("stall_valid_%0d", i), {31'b0, INSTR_VALID}, 32'd1);
        end
        check("stall_count", {16'b0, FETCH_COUNT}, 32'd2);
        INSTR_READY = 1'b1;
        tick();
        check("unstall_pc3", {24'b0, INSTR_PC}, 32'd3);
        check("unstall_count", {16'b0, FETCH_COUNT}, 32'd3);
        tick();
        check("unstall_pc4", {24'b0, INSTR_PC}, 32'd4);
        check("unstall_count4", {16'b0, FETCH_COUNT}, 32'd4);

        // Reset mid-run with a valid instruction pending
        RESET_N = 1'b0;
        tick();
        check("midrst_valid", {31'b0, INSTR_VALID}, 32'd0);
        check("midrst_instr", INSTR, 32'd0);
        check("midrst_instr_pc", {24'b0, INSTR_PC}, 32'd0);
        check("midrst_count", {16'b0, FETCH_COUNT}, 32'd0);
        check("midrst_mem_addr", {24'b0, MEM_ADDR}, 32'd0);
        RESET_N = 1'b1;
        tick(); tick();
        check("midrst_idle_valid", {31'b0, INSTR_VALID}, 32'd0);
        check("midrst_idle_addr", {24'b0, MEM_ADDR}, 32'd0);

        // Redirect squashes a non-accepted instruction
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        check("redir_pc0", {24'b0, INSTR_PC}, 32'd0);
        tick();
        check("redir_pc1", {24'b0, INSTR_PC}, 32'd1);
        INSTR_READY = 1'b0; REDIRECT = 1'b1; REDIRECT_PC = 8'h05;
        tick();
        REDIRECT = 1'b0; INSTR_READY = 1'b1;
        check("redir_squash_valid", {31'b0, INSTR_VALID}, 32'd0);
        check("redir_squash_count", {16'b0, FETCH_COUNT}, 32'd1);
        check("redir_mem_addr", {24'b0, MEM_ADDR}, 32'd5);
        tick();
        check("redir_target_pc", {24'b0, INSTR_PC}, 32'd5);
        check("redir_target_instr", INSTR, 32'hD002_0000);
        check("redir_target_count", {16'b0, FETCH_COUNT}, 32'd1);
        tick(); tick();
        check("near_halt_pc7", {24'b0, INSTR_PC}, 32'd7);
        check("near_halt_instr7", INSTR, 32'hF800_0001);
        tick();
        check("near_halt_not_halt", {24'b0, INSTR_PC}, 32'd8);
        tick();
        check("drain_pc9", {24'b0, INSTR_PC}, 32'd9);
        check("drain_count", {16'b0, FETCH_COUNT}, 32'd5);

        // Halt word held in DRAIN, then cancelled by a redirect
        INSTR_READY = 1'b0;
        tick();
        check("drain_hold_valid", {31'b0, INSTR_VALID}, 32'd1);
        check("drain_hold_instr", INSTR, 32'hF800_0000);
        check("drain_hold_addr", {24'b0, MEM_ADDR}, 32'd9);
        REDIRECT = 1'b1; REDIRECT_PC = 8'h03;
        tick();
        REDIRECT = 1'b0; INSTR_READY = 1'b1;
        check("cancel_halted", {31'b0, HALTED}, 32'd0);
        check("cancel_valid", {31'b0, INSTR_VALID}, 32'd0);
        check("cancel_count", {16'b0, FETCH_COUNT}, 32'd5);
        tick();
        check("cancel_resume_pc", {24'b0, INSTR_PC}, 32'd3);
        check("cancel_resume_instr", INSTR, 32'h3003_0003);
        tick();
        check("cancel_next_pc", {24'b0, INSTR_PC}, 32'd4);
        check("cancel_next_count", {16'b0, FETCH_COUNT}, 32'd6);

        // Accepted-on-redirect still counts; then PC wrap 255 -> 0 on zeroed memory
        for (int i = 0; i < 10; i++) mem[i] = 32'h0;
        REDIRECT = 1'b1; REDIRECT_PC = 8'hFF;
        tick();
        REDIRECT = 1'b0;
        check("wrap_redir_count", {16'b0, FETCH_COUNT}, 32'd7);
        check("wrap_redir_addr", {24'b0, MEM_ADDR}, 32'hFF);
        tick();
        check("wrap_pc255", {24'b0, INSTR_PC}, 32'hFF);
        check("wrap_instr255", INSTR, 32'h0);
        tick();
        check("wrap_pc0", {24'b0, INSTR_PC}, 32'd0);
        check("wrap_valid", {31'b0, INSTR_VALID}, 32'd1);
        check("wrap_count", {16'b0, FETCH_COUNT}, 32'd8);
        check("wrap_mem_addr", {24'b0, MEM_ADDR}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
